// File: rtl/pc_control_if.sv
// pc_control bus: instruction/datapath inputs and next-PC/flag/halt outputs.
interface pc_control_if;
  logic [15:0] instr;
  logic        stall;
  logic [15:0] alu_out;
  logic        alu_ovfl;
  logic [15:0] br_target;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [2:0]  flags;
  logic        branch_taken;
  logic        hlt;

  modport master (
    output instr, stall, alu_out, alu_ovfl, br_target,
    input  pc, pc_inc, flags, branch_taken, hlt
  );

  modport slave (
    input  instr, stall, alu_out, alu_ovfl, br_target,
    output pc, pc_inc, flags, branch_taken, hlt
  );
endinterface

// File: rtl/pc_control.sv
// Next-PC, N/Z/V flag and halt unit for the single-cycle CPU.
// Owns the architectural PC; branches see flags from earlier instructions.
module pc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic clk,
  input  logic rst,
  pc_control_if.slave bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;

  logic [3:0]  op;
  logic [15:0] pc_inc;
  logic [15:0] b_off;
  logic [15:0] next_pc;
  logic        n, z, v;
  logic        cond;
  logic        is_b, is_br, is_hlt;
  logic        arith, zonly;
  logic        run, go;

  assign op     = bus.instr[15:12];
  assign pc_inc = pc_q + 16'd2;
  assign b_off  = {{6{bus.instr[8]}}, bus.instr[8:0], 1'b0};
  assign n      = flags_q[2];
  assign z      = flags_q[1];
  assign v      = flags_q[0];

  assign is_b   = (op == 4'hC);
  assign is_br  = (op == 4'hD);
  assign is_hlt = (op == 4'hF);
  assign arith  = (op == 4'h0) || (op == 4'h1);
  assign zonly  = (op >= 4'h3) && (op <= 4'h6);

  assign run = (state_q == RUN);
  assign go  = run && !bus.stall;

  always_comb begin
    cond = 1'b0;
    unique case (bus.instr[11:9])
      3'd0: cond = !z;
      3'd1: cond = z;
      3'd2: cond = !z && !n;
      3'd3: cond = n;
      3'd4: cond = z || (!z && !n);
      3'd5: cond = n || z;
      3'd6: cond = v;
      3'd7: cond = 1'b1;
    endcase
  end

  always_comb begin
    next_pc = pc_inc;
    unique case (1'b1)
      is_b && cond:  next_pc = pc_inc + b_off;
      is_br && cond: next_pc = bus.br_target;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    if (go) begin
      if (is_hlt) begin
        state_d = HALTED;
      end else begin
        pc_d = next_pc;
        unique case (1'b1)
          arith: flags_d = {bus.alu_out[15],
                            bus.alu_out == 16'd0,
                            bus.alu_ovfl};
          zonly: flags_d[1] = (bus.alu_out == 16'd0);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_inc       = pc_inc;
  assign bus.flags        = flags_q;
  assign bus.branch_taken = run && (is_b || is_br) && cond;
  assign bus.hlt          = (state_q == HALTED);

endmodule

// File: tb/tb_pc_control.sv
// Scoreboard bench for pc_control: directed scenarios then random traffic
// against an instruction-level reference model.
module tb_pc_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_control_if bus ();

  pc_control #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [2:0]  flags;
    logic        bt;
    logic        hlt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] m_pc;
  logic [2:0]  m_flags;
  logic        m_halt;
  logic        m_valid = 1'b0;

  function automatic logic cond_ok(logic [2:0] c, logic [2:0] f);
    logic fn, fz, fv;
    fn = f[2];
    fz = f[1];
    fv = f[0];
    case (c)
      3'd0: return !fz;
      3'd1: return fz;
      3'd2: return !fz && !fn;
      3'd3: return fn;
      3'd4: return fz || (!fz && !fn);
      3'd5: return fn || fz;
      3'd6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic taken(logic [15:0] i);
    if (m_halt) return 1'b0;
    if (i[15:12] != 4'hC && i[15:12] != 4'hD) return 1'b0;
    return cond_ok(i[11:9], m_flags);
  endfunction

  function automatic logic [15:0] target(logic [15:0] i, logic [15:0] t);
    int off;
    if (!taken(i)) return m_pc + 16'd2;
    if (i[15:12] == 4'hD) return t;
    off = int'($signed(i[8:0])) * 2;
    return 16'(int'(m_pc) + 2 + off);
  endfunction

  task automatic step(input logic [15:0] i, input logic s,
                      input logic [15:0] a, input logic o,
                      input logic [15:0] t, input logic r);
    exp_t e;
    logic [15:0] nxt;
    bus.instr     = i;
    bus.stall     = s;
    bus.alu_out   = a;
    bus.alu_ovfl  = o;
    bus.br_target = t;
    rst           = r;
    if (m_valid) begin
      e.pc     = m_pc;
      e.pc_inc = m_pc + 16'd2;
      e.flags  = m_flags;
      e.bt     = taken(i);
      e.hlt    = m_halt;
      exp_q.push_back(e);
    end
    nxt = m_valid ? target(i, t) : 16'h0;
    @(posedge clk);
    if (r) begin
      m_pc    = 16'h0000;
      m_flags = 3'b000;
      m_halt  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && !m_halt && !s) begin
      if (i[15:12] == 4'hF) begin
        m_halt = 1'b1;
      end else begin
        m_pc = nxt;
        if (i[15:12] <= 4'h1)
          m_flags = {a[15], a == 16'h0, o};
        else if (i[15:12] >= 4'h3 && i[15:12] <= 4'h6)
          m_flags[1] = (a == 16'h0);
      end
    end
    #1;
  endtask

  task automatic run_op(input logic [15:0] i, input logic [15:0] a,
                        input logic o, input logic [15:0] t);
    step(i, 1'b0, a, o, t, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    for (int k = 0; k < cycles; k++)
      step(16'h2000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic nops_until(input logic [15:0] want);
    for (int k = 0; k < 200 && m_pc != want; k++)
      run_op(16'h2000, 16'h1, 1'b0, 16'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.pc !== e.pc) begin
        n_bad++;
        $display("FAIL pc got %h want %h t=%0t", bus.pc, e.pc, $time);
      end
      n_cmp++;
      if (bus.pc_inc !== e.pc_inc) begin
        n_bad++;
        $display("FAIL pc_inc got %h want %h t=%0t",
                 bus.pc_inc, e.pc_inc, $time);
      end
      n_cmp++;
      if (bus.flags !== e.flags) begin
        n_bad++;
        $display("FAIL flags got %b want %b t=%0t",
                 bus.flags, e.flags, $time);
      end
      n_cmp++;
      if (bus.branch_taken !== e.bt) begin
        n_bad++;
        $display("FAIL branch_taken got %b want %b t=%0t",
                 bus.branch_taken, e.bt, $time);
      end
      n_cmp++;
      if (bus.hlt !== e.hlt) begin
        n_bad++;
        $display("FAIL hlt got %b want %b t=%0t", bus.hlt, e.hlt, $time);
      end
    end
  end

  initial begin
    logic [15:0] ri, ra;
    bus.instr = 16'h2000;
    bus.stall = 1'b0;
    bus.alu_out = 16'h0;
    bus.alu_ovfl = 1'b0;
    bus.br_target = 16'h0;
    rst = 1'b1;
    m_pc = 16'h0;
    m_flags = 3'b0;
    m_halt = 1'b0;
    @(posedge clk);
    #1;

    // reset and sequential fetch
    do_reset(2);
    run_op(16'h0000, 16'h0005, 1'b0, 16'h0);
    run_op(16'h2000, 16'h0, 1'b0, 16'h0);
    run_op(16'h2000, 16'h0, 1'b0, 16'h0);

    // flags then conditional B
    nops_until(16'h000E);
    run_op(16'h1000, 16'h0000, 1'b0, 16'h0);
    run_op(16'hC206, 16'h0, 1'b0, 16'h0);
    run_op(16'hC006, 16'h0, 1'b0, 16'h0);
    run_op(16'h2000, 16'h0, 1'b0, 16'h0);

    // negative offset and wrap
    do_reset(1);
    run_op(16'hCFFF, 16'h0, 1'b0, 16'h0);
    run_op(16'hDE30, 16'h0, 1'b0, 16'hFFFE);
    run_op(16'h2000, 16'h0, 1'b0, 16'h0);

    // BR and non-flag instructions
    run_op(16'h0000, 16'h8000, 1'b1, 16'h0);
    run_op(16'h3000, 16'h0000, 1'b0, 16'h0);
    run_op(16'h3000, 16'h8000, 1'b0, 16'h0);
    run_op(16'hDE30, 16'h0, 1'b0, 16'h1234);
    run_op(16'h8000, 16'h0000, 1'b1, 16'h0);
    run_op(16'hCC02, 16'h0, 1'b0, 16'h0);

    // stall holds everything
    for (int k = 0; k < 3; k++)
      step(16'h0000, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
    run_op(16'h0000, 16'h0, 1'b0, 16'h0);
    run_op(16'h2000, 16'h0, 1'b0, 16'h0);

    // halt, stalled HLT, reset from halt
    do_reset(1);
    nops_until(16'h0020);
    step(16'hF000, 1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
    run_op(16'hF000, 16'h0, 1'b0, 16'h0);
    for (int k = 0; k < 6; k++)
      run_op(16'(k * 16'h2345 + 16'hCE00), 16'h0, 1'b0, 16'h4444);
    do_reset(1);
    run_op(16'h2000, 16'h0, 1'b0, 16'h0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      ri = 16'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      step(ri, $urandom_range(0, 3) == 0, ra, 1'($urandom),
           16'($urandom), $urandom_range(0, 24) == 0);
    end
    run_op(16'h2000, 16'h0, 1'b0, 16'h0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
